// File: rtl/mdu_share_arb.sv
// Round-robin front end sharing one MDU between REQ_COUNT issue queues, with an
// in-order owner FIFO that steers results back. Define MDU_ARB_PERF_EN for perf counters.
module mdu_share_arb #(
    parameter int REQ_COUNT = 2,
    parameter int DEPTH     = 4,
    parameter int ROB_ID_W  = 6,
    parameter int OP_W      = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            flush,
    input  logic [REQ_COUNT-1:0]            req_valid_i,
    output logic [REQ_COUNT-1:0]            req_ready_o,
    input  logic [REQ_COUNT*64-1:0]         req_data_i,
    input  logic [REQ_COUNT*OP_W-1:0]       req_op_i,
    input  logic [REQ_COUNT*ROB_ID_W-1:0]   req_rob_id_i,
    output logic                            mdu_valid_o,
    input  logic                            mdu_ready_i,
    output logic [63:0]                     mdu_data_o,
    output logic [OP_W-1:0]                 mdu_op_o,
    output logic [ROB_ID_W-1:0]             mdu_rob_id_o,
    input  logic                            mdu_res_valid_i,
    output logic                            mdu_res_ready_o,
    input  logic [31:0]                     mdu_res_data_i,
    input  logic [ROB_ID_W-1:0]             mdu_res_rob_id_i,
    output logic [REQ_COUNT-1:0]            res_valid_o,
    input  logic [REQ_COUNT-1:0]            res_ready_i,
    output logic [31:0]                     res_data_o,
    output logic [ROB_ID_W-1:0]             res_rob_id_o
`ifdef MDU_ARB_PERF_EN
    ,
    output logic [REQ_COUNT*32-1:0]         perf_grant_o,
    output logic [31:0]                     perf_full_stall_o,
    output logic [31:0]                     perf_busy_stall_o
`endif
);
    localparam int IDX_W = $clog2(REQ_COUNT);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] gnt_idx;
    logic             found;
    logic             can_accept;
    logic             accept;
    logic [REQ_COUNT-1:0] grant;

    logic [IDX_W-1:0] owner_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic [IDX_W-1:0] head;
    logic             fifo_empty;
    logic             pop;

    assign fifo_empty = (count == '0);
    assign head       = owner_mem[rd_ptr];
    // A same-cycle pop deliberately does not open a slot for a new accept.
    assign can_accept = rst_n && !flush && (count < DEPTH_C) && (!mdu_valid_o || mdu_ready_i);

    always_comb begin
        gnt_idx = '0;
        found   = 1'b0;
        for (int k = 0; k < REQ_COUNT; k++) begin
            int idx;
            idx = (int'(rr_ptr) + k) % REQ_COUNT;
            if (!found && req_valid_i[idx]) begin
                found   = 1'b1;
                gnt_idx = IDX_W'(idx);
            end
        end
        grant = '0;
        if (can_accept && found) grant = REQ_COUNT'(1) << gnt_idx;
    end

    assign accept      = |grant;
    assign req_ready_o = grant;

    assign mdu_res_ready_o = rst_n && (fifo_empty ? 1'b1 : res_ready_i[head]);
    assign pop             = mdu_res_valid_i && mdu_res_ready_o && !fifo_empty;
    assign res_valid_o     = (fifo_empty || !mdu_res_valid_i) ? '0 : (REQ_COUNT'(1) << head);
    assign res_data_o      = rst_n ? mdu_res_data_i : '0;
    assign res_rob_id_o    = rst_n ? mdu_res_rob_id_i : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr       <= '0;
            mdu_valid_o  <= 1'b0;
            mdu_data_o   <= '0;
            mdu_op_o     <= '0;
            mdu_rob_id_o <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
        end else if (flush) begin
            rr_ptr      <= '0;
            mdu_valid_o <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
        end else begin
            if (accept) begin
                rr_ptr       <= (gnt_idx == IDX_W'(REQ_COUNT-1)) ? '0 : gnt_idx + 1'b1;
                mdu_valid_o  <= 1'b1;
                mdu_data_o   <= req_data_i[gnt_idx*64 +: 64];
                mdu_op_o     <= req_op_i[gnt_idx*OP_W +: OP_W];
                mdu_rob_id_o <= req_rob_id_i[gnt_idx*ROB_ID_W +: ROB_ID_W];
                wr_ptr       <= wr_ptr + 1'b1;
            end else if (mdu_ready_i) begin
                mdu_valid_o <= 1'b0;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (accept && !pop)      count <= count + 1'b1;
            else if (pop && !accept) count <= count - 1'b1;
        end
    end

    // Owner entries are payload only; occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (accept && !flush) owner_mem[wr_ptr] <= gnt_idx;
    end

`ifdef MDU_ARB_PERF_EN
    logic any_req;
    assign any_req = |req_valid_i;

    for (genvar g = 0; g < REQ_COUNT; g++) begin : g_perf
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) perf_grant_o[g*32 +: 32] <= '0;
            else if (grant[g] && perf_grant_o[g*32 +: 32] != 32'hFFFF_FFFF)
                perf_grant_o[g*32 +: 32] <= perf_grant_o[g*32 +: 32] + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_full_stall_o <= '0;
            perf_busy_stall_o <= '0;
        end else begin
            if (any_req && count == DEPTH_C && perf_full_stall_o != 32'hFFFF_FFFF)
                perf_full_stall_o <= perf_full_stall_o + 1'b1;
            if (any_req && mdu_valid_o && !mdu_ready_i && perf_busy_stall_o != 32'hFFFF_FFFF)
                perf_busy_stall_o <= perf_busy_stall_o + 1'b1;
        end
    end
`endif
endmodule
